// File: rtl/intra_mb_scheduler_pkg.sv
// Shared types and geometry helpers for the intra-prediction path
// (scheduler, saver and predictors).
package intra_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_PRED,
    SAVE,
    NEXT,
    DONE
  } state_t;

  localparam int MBNUM_W = 13;
  localparam int MBX_W   = 7;
  localparam int MBY_W   = 6;
  localparam int PIXX_W  = 11;
  localparam int PIXY_W  = 10;
  localparam int TMO_W   = 10;

  function automatic int mbs_per_row(input int length, input int mb_size_l);
    return length / mb_size_l;
  endfunction

  function automatic int mb_rows(input int width, input int mb_size_w);
    return width / mb_size_w;
  endfunction

  function automatic int mb_count(input int length, input int width,
                                  input int mb_size_l, input int mb_size_w);
    return mbs_per_row(length, mb_size_l) * mb_rows(width, mb_size_w);
  endfunction

  // MB sizes are powers of two, so pixel origins are a plain left shift.
  function automatic int mb_shift(input int mb_size);
    return $clog2(mb_size);
  endfunction

endpackage

// File: rtl/intra_mb_scheduler_if.sv
// Bundle between the frame scheduler and its environment (frame control,
// prediction datapath, residue/mode saver).
interface intra_mb_scheduler_if;
  import intra_pkg::*;

  // Handshakes: pred_start is a one-cycle pulse answered later by a
  // one-cycle pred_done. save_enable is a valid that stays high until a
  // cycle where save_ready is also high; that cycle is the single transfer,
  // and save_enable is low from the following cycle.
  logic               frame_start;
  logic               pred_start;
  logic               pred_done;
  logic               save_enable;
  logic               save_ready;
  logic [MBNUM_W-1:0] mbnumber;
  logic [MBX_W-1:0]   mb_x;
  logic [MBY_W-1:0]   mb_y;
  logic [PIXX_W-1:0]  pix_x;
  logic [PIXY_W-1:0]  pix_y;
  logic               busy;
  logic               frame_done;
  logic               err;
  state_t             dbg_state;

  modport master (
    output frame_start, pred_done, save_ready,
    input  pred_start, save_enable, mbnumber, mb_x, mb_y, pix_x, pix_y,
           busy, frame_done, err, dbg_state
  );

  modport slave (
    input  frame_start, pred_done, save_ready,
    output pred_start, save_enable, mbnumber, mb_x, mb_y, pix_x, pix_y,
           busy, frame_done, err, dbg_state
  );

endinterface

// File: rtl/intra_mb_scheduler_mb_raster_counter.sv
// Raster-order macroblock position: linear index plus column/row kept in
// step, so consumers never divide or take a modulo.
module mb_raster_counter
  import intra_pkg::*;
#(
  parameter int MBS_PER_ROW = 80,
  parameter int MB_COUNT    = 3600
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               advance,
  output logic [MBNUM_W-1:0] mbnumber,
  output logic [MBX_W-1:0]   mb_x,
  output logic [MBY_W-1:0]   mb_y,
  output logic               last
);

  localparam logic [MBNUM_W-1:0] LAST_NUM = MBNUM_W'(MB_COUNT - 1);
  localparam logic [MBX_W-1:0]   LAST_X   = MBX_W'(MBS_PER_ROW - 1);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      mbnumber <= '0;
      mb_x     <= '0;
      mb_y     <= '0;
    end else if (advance) begin
      mbnumber <= mbnumber + 1'b1;
      if (mb_x == LAST_X) begin
        mb_x <= '0;
        mb_y <= mb_y + 1'b1;
      end else begin
        mb_x <= mb_x + 1'b1;
      end
    end
  end

  assign last = (mbnumber == LAST_NUM);

endmodule

// File: rtl/intra_mb_scheduler.sv
// Frame-level sequencer: walks one frame's macroblocks in raster order,
// starts prediction per MB, and hands each finished MB to the saver.
module intra_mb_scheduler
  import intra_pkg::*;
#(
  parameter int LENGTH    = 1280,
  parameter int WIDTH     = 720,
  parameter int MB_SIZE_L = 16,
  parameter int MB_SIZE_W = 16,
  parameter int TIMEOUT   = 1023
) (
  input logic                  clk,
  input logic                  reset,
  intra_mb_scheduler_if.slave  bus
);

  localparam int MBS_PER_ROW = mbs_per_row(LENGTH, MB_SIZE_L);
  localparam int MB_COUNT    = mb_count(LENGTH, WIDTH, MB_SIZE_L, MB_SIZE_W);
  localparam int SHIFT_L     = mb_shift(MB_SIZE_L);
  localparam int SHIFT_W     = mb_shift(MB_SIZE_W);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT);

  state_t             state, state_next;
  logic [TMO_W-1:0]   tmo_cnt;
  logic               clr_pos, adv_pos, timeout_hit, last;
  logic               pred_start_q, save_enable_q, busy_q, frame_done_q, err_q;
  logic [MBNUM_W-1:0] mbnumber;
  logic [MBX_W-1:0]   mb_x;
  logic [MBY_W-1:0]   mb_y;

  mb_raster_counter #(
    .MBS_PER_ROW (MBS_PER_ROW),
    .MB_COUNT    (MB_COUNT)
  ) u_pos (
    .clk      (clk),
    .reset    (reset),
    .clear    (clr_pos),
    .advance  (adv_pos),
    .mbnumber (mbnumber),
    .mb_x     (mb_x),
    .mb_y     (mb_y),
    .last     (last)
  );

  always_comb begin
    state_next  = state;
    clr_pos     = 1'b0;
    adv_pos     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (bus.frame_start) begin
          clr_pos    = 1'b1;
          state_next = START;
        end
      end
      START:     state_next = WAIT_PRED;
      WAIT_PRED: begin
        // A completion arriving on the timeout cycle still counts.
        if (bus.pred_done) begin
          state_next = SAVE;
        end else if (tmo_cnt == TMO_LIMIT) begin
          timeout_hit = 1'b1;
          state_next  = NEXT;
        end
      end
      SAVE: begin
        if (bus.save_ready) state_next = NEXT;
      end
      NEXT: begin
        if (last) begin
          state_next = DONE;
        end else begin
          adv_pos    = 1'b1;
          state_next = START;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control outputs are decoded from the next state so they leave flops
  // aligned with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      tmo_cnt       <= '0;
      pred_start_q  <= 1'b0;
      save_enable_q <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state <= state_next;
      if (state == START) begin
        tmo_cnt <= '0;
      end else if (state == WAIT_PRED) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      pred_start_q  <= (state_next == START);
      save_enable_q <= (state_next == SAVE);
      busy_q        <= (state_next != IDLE);
      frame_done_q  <= (state_next == DONE);
      if (clr_pos) begin
        err_q <= 1'b0;
      end else if (timeout_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.pred_start  = pred_start_q;
  assign bus.save_enable = save_enable_q;
  assign bus.busy        = busy_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.err         = err_q;
  assign bus.mbnumber    = mbnumber;
  assign bus.mb_x        = mb_x;
  assign bus.mb_y        = mb_y;
  assign bus.pix_x       = PIXX_W'(mb_x) << SHIFT_L;
  assign bus.pix_y       = PIXY_W'(mb_y) << SHIFT_W;
  assign bus.dbg_state   = state;

endmodule

// File: tb/tb_intra_mb_scheduler.sv
// Directed bench for intra_mb_scheduler on a 64x32 frame of 16x16 MBs
// (4 columns x 2 rows) with a 7-cycle prediction timeout.
module tb_intra_mb_scheduler;
  import intra_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;

  intra_mb_scheduler_if bus ();

  intra_mb_scheduler #(
    .LENGTH    (64),
    .WIDTH     (32),
    .MB_SIZE_L (16),
    .MB_SIZE_W (16),
    .TIMEOUT   (7)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- monitor ----------------
  logic mon_clr = 1'b0;
  int   ps_count, fd_count;
  int   se_cyc[8];
  int   acc[8];

  always @(negedge clk) begin
    if (mon_clr) begin
      ps_count <= 0;
      fd_count <= 0;
      for (int i = 0; i < 8; i++) begin
        se_cyc[i] <= 0;
        acc[i]    <= 0;
      end
    end else begin
      if (bus.pred_start === 1'b1) ps_count <= ps_count + 1;
      if (bus.frame_done === 1'b1) fd_count <= fd_count + 1;
      if (bus.save_enable === 1'b1 && bus.mbnumber < 8) begin
        se_cyc[bus.mbnumber] <= se_cyc[bus.mbnumber] + 1;
        if (bus.save_ready === 1'b1) acc[bus.mbnumber] <= acc[bus.mbnumber] + 1;
      end
    end
  end

  // ---------------- expected geometry ----------------
  integer exp_x[8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
  integer exp_y[8]  = '{0, 0, 0, 0, 1, 1, 1, 1};
  integer exp_px[8] = '{0, 16, 32, 48, 0, 16, 32, 48};
  integer exp_py[8] = '{0, 0, 0, 0, 16, 16, 16, 16};

  // ---------------- driver ----------------
  int     pd_dly[8];   // WAIT_PRED cycles before pred_done; -1 = never
  int     sr_low[8];   // SAVE cycles with save_ready low
  int     fs_mb, abort_mb;
  int     ps_cyc[8];
  integer rec_n[8], rec_x[8], rec_y[8], rec_px[8], rec_py[8], rec_err[8];
  int     done_cyc;
  logic   done_err;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_defaults();
    for (int i = 0; i < 8; i++) begin
      pd_dly[i] = 0;
      sr_low[i] = 0;
    end
    fs_mb           = -1;
    abort_mb        = -1;
    bus.frame_start = 1'b0;
    bus.pred_done   = 1'b0;
    bus.save_ready  = 1'b1;
  endtask

  task automatic drive_frame(output bit ok);
    int n;
    ok       = 1'b1;
    done_cyc = -1;
    done_err = 1'bx;
    for (int i = 0; i < 8; i++) begin
      rec_n[i] = 'x; rec_x[i] = 'x; rec_y[i] = 'x;
      rec_px[i] = 'x; rec_py[i] = 'x; rec_err[i] = 'x; ps_cyc[i] = -100;
    end
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    for (int mb = 0; mb < 8; mb++) begin
      n = 0;
      while (bus.pred_start !== 1'b1 && n < 40) begin
        tick();
        n++;
      end
      if (bus.pred_start !== 1'b1) begin
        ok = 1'b0;
        return;
      end
      ps_cyc[mb]  = cyc;
      rec_n[mb]   = bus.mbnumber;
      rec_x[mb]   = bus.mb_x;
      rec_y[mb]   = bus.mb_y;
      rec_px[mb]  = bus.pix_x;
      rec_py[mb]  = bus.pix_y;
      rec_err[mb] = bus.err;
      if (mb == fs_mb) bus.frame_start = 1'b1;
      tick();
      bus.frame_start = 1'b0;
      if (pd_dly[mb] >= 0) begin
        repeat (pd_dly[mb]) tick();
        bus.pred_done  = 1'b1;
        bus.save_ready = (sr_low[mb] == 0);
        tick();
        bus.pred_done = 1'b0;
        if (mb == abort_mb) return;
        if (sr_low[mb] > 0) begin
          repeat (sr_low[mb]) tick();
          bus.save_ready = 1'b1;
        end
      end
    end
    n = 0;
    while (bus.frame_done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (bus.frame_done !== 1'b1) begin
      ok = 1'b0;
      return;
    end
    done_cyc = cyc;
    done_err = bus.err;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    set_defaults();
    bus.save_ready = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    nvec++;
    if ({bus.busy, bus.pred_start, bus.save_enable, bus.frame_done, bus.err} !== 5'b0) begin
      nerr++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {bus.busy, bus.pred_start, bus.save_enable, bus.frame_done, bus.err});
    end
    nvec++;
    if ({bus.mbnumber, bus.mb_x, bus.mb_y} !== 26'd0) begin
      nerr++;
      $display("FAIL reset_pos: got n=%0d x=%0d y=%0d want 0", bus.mbnumber, bus.mb_x, bus.mb_y);
    end
    nvec++;
    if ({bus.pix_x, bus.pix_y} !== 21'd0) begin
      nerr++;
      $display("FAIL reset_pix: got %0d,%0d want 0,0", bus.pix_x, bus.pix_y);
    end
    nvec++;
    if (bus.dbg_state !== IDLE) begin
      nerr++;
      $display("FAIL reset_state: got %0d want IDLE", bus.dbg_state);
    end
    bus.pred_done  = 1'b1;
    bus.save_ready = 1'b1;
    tick();
    bus.pred_done = 1'b0;
    tick();
    nvec++;
    if ({bus.busy, bus.pred_start, bus.save_enable, bus.dbg_state} !== {3'b000, IDLE}) begin
      nerr++;
      $display("FAIL reset_ignore_pred_done: got busy=%b ps=%b se=%b st=%0d want idle",
               bus.busy, bus.pred_start, bus.save_enable, bus.dbg_state);
    end
  endtask

  task automatic test_nominal();
    bit ok;
    set_defaults();
    drive_frame(ok);
    nvec++;
    if (!ok) begin
      nerr++;
      $display("FAIL nominal_complete: frame stalled, want 8 MBs and frame_done");
    end
    for (int mb = 0; mb < 8; mb++) begin
      nvec++;
      if (rec_n[mb] !== mb || rec_x[mb] !== exp_x[mb] || rec_y[mb] !== exp_y[mb] ||
          rec_px[mb] !== exp_px[mb] || rec_py[mb] !== exp_py[mb]) begin
        nerr++;
        $display("FAIL nominal_pos mb%0d: got n=%0d x=%0d y=%0d px=%0d py=%0d want %0d %0d %0d %0d %0d",
                 mb, rec_n[mb], rec_x[mb], rec_y[mb], rec_px[mb], rec_py[mb],
                 mb, exp_x[mb], exp_y[mb], exp_px[mb], exp_py[mb]);
      end
    end
    for (int mb = 1; mb < 8; mb++) begin
      nvec++;
      if (ps_cyc[mb] - ps_cyc[mb-1] != 4) begin
        nerr++;
        $display("FAIL nominal_period mb%0d: got %0d cycles want 4", mb, ps_cyc[mb] - ps_cyc[mb-1]);
      end
    end
    nvec++;
    if (done_cyc - ps_cyc[7] != 4) begin
      nerr++;
      $display("FAIL nominal_done_latency: got %0d want 4", done_cyc - ps_cyc[7]);
    end
    tick();
    nvec++;
    if ({bus.busy, bus.frame_done} !== 2'b00) begin
      nerr++;
      $display("FAIL nominal_after_done: got busy=%b fd=%b want 0 0", bus.busy, bus.frame_done);
    end
    nvec++;
    if (bus.mbnumber !== 13'd7 || bus.mb_x !== 7'd3 || bus.mb_y !== 6'd1) begin
      nerr++;
      $display("FAIL nominal_hold: got n=%0d x=%0d y=%0d want 7 3 1", bus.mbnumber, bus.mb_x, bus.mb_y);
    end
    tick();
    nvec++;
    if (ps_count != 8 || fd_count != 1 || acc[0] + acc[3] + acc[7] != 3) begin
      nerr++;
      $display("FAIL nominal_counts: got ps=%0d fd=%0d acc(0,3,7)=%0d want 8 1 3",
               ps_count, fd_count, acc[0] + acc[3] + acc[7]);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    set_defaults();
    sr_low[2] = 5;
    drive_frame(ok);
    tick();
    nvec++;
    if (!ok) begin
      nerr++;
      $display("FAIL bp_complete: frame stalled, want frame_done");
    end
    nvec++;
    if (se_cyc[2] != 6) begin
      nerr++;
      $display("FAIL bp_hold: got save_enable %0d cycles on mb2 want 6", se_cyc[2]);
    end
    nvec++;
    if (acc[2] != 1) begin
      nerr++;
      $display("FAIL bp_accept: got %0d acceptances on mb2 want 1", acc[2]);
    end
    nvec++;
    if (ps_cyc[3] - ps_cyc[2] != 9) begin
      nerr++;
      $display("FAIL bp_period: got %0d cycles want 9", ps_cyc[3] - ps_cyc[2]);
    end
    nvec++;
    if (ps_count != 8 || rec_n[3] !== 3) begin
      nerr++;
      $display("FAIL bp_starts: got ps=%0d next_n=%0d want 8 3", ps_count, rec_n[3]);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    set_defaults();
    pd_dly[5] = -1;
    drive_frame(ok);
    nvec++;
    if (!ok) begin
      nerr++;
      $display("FAIL tmo_complete: frame stalled, want frame_done");
    end
    nvec++;
    if (ps_cyc[6] - ps_cyc[5] != 10) begin
      nerr++;
      $display("FAIL tmo_period: got %0d cycles want 10", ps_cyc[6] - ps_cyc[5]);
    end
    nvec++;
    if (rec_err[5] !== 1'b0 || rec_err[6] !== 1'b1 || rec_n[6] !== 6) begin
      nerr++;
      $display("FAIL tmo_err_set: got err5=%0d err6=%0d n6=%0d want 0 1 6", rec_err[5], rec_err[6], rec_n[6]);
    end
    nvec++;
    if (done_err !== 1'b1) begin
      nerr++;
      $display("FAIL tmo_err_at_done: got %b want 1", done_err);
    end
    tick();
    tick();
    nvec++;
    if (se_cyc[5] != 0 || acc[5] != 0) begin
      nerr++;
      $display("FAIL tmo_no_save: got se=%0d acc=%0d on mb5 want 0 0", se_cyc[5], acc[5]);
    end
    nvec++;
    if (bus.err !== 1'b1 || fd_count != 1 || ps_count != 8) begin
      nerr++;
      $display("FAIL tmo_sticky: got err=%b fd=%0d ps=%0d want 1 1 8", bus.err, fd_count, ps_count);
    end
  endtask

  task automatic test_collisions();
    bit ok;
    set_defaults();
    pd_dly[1] = 7;
    fs_mb     = 3;
    drive_frame(ok);
    tick();
    nvec++;
    if (!ok) begin
      nerr++;
      $display("FAIL col_complete: frame stalled, want frame_done");
    end
    nvec++;
    if (rec_err[0] !== 1'b0) begin
      nerr++;
      $display("FAIL col_err_cleared: got %0d want 0", rec_err[0]);
    end
    nvec++;
    if (acc[1] != 1 || se_cyc[1] != 1) begin
      nerr++;
      $display("FAIL col_pred_wins: got acc=%0d se=%0d on mb1 want 1 1", acc[1], se_cyc[1]);
    end
    nvec++;
    if (ps_cyc[2] - ps_cyc[1] != 11) begin
      nerr++;
      $display("FAIL col_period: got %0d cycles want 11", ps_cyc[2] - ps_cyc[1]);
    end
    nvec++;
    if (done_err !== 1'b0) begin
      nerr++;
      $display("FAIL col_no_err: got %b want 0", done_err);
    end
    nvec++;
    if (ps_count != 8 || fd_count != 1 || rec_n[4] !== 4 || rec_n[7] !== 7) begin
      nerr++;
      $display("FAIL col_frame_start_ignored: got ps=%0d fd=%0d n4=%0d n7=%0d want 8 1 4 7",
               ps_count, fd_count, rec_n[4], rec_n[7]);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    set_defaults();
    sr_low[3] = 3;
    abort_mb  = 3;
    drive_frame(ok);
    nvec++;
    if (bus.dbg_state !== SAVE || bus.save_enable !== 1'b1 || bus.mbnumber !== 13'd3) begin
      nerr++;
      $display("FAIL mid_in_save: got st=%0d se=%b n=%0d want SAVE 1 3",
               bus.dbg_state, bus.save_enable, bus.mbnumber);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    nvec++;
    if (bus.dbg_state !== IDLE || {bus.save_enable, bus.busy, bus.pred_start} !== 3'b000) begin
      nerr++;
      $display("FAIL mid_abort: got st=%0d se=%b busy=%b ps=%b want IDLE 0 0 0",
               bus.dbg_state, bus.save_enable, bus.busy, bus.pred_start);
    end
    nvec++;
    if (bus.mbnumber !== 13'd0 || bus.mb_x !== 7'd0) begin
      nerr++;
      $display("FAIL mid_pos_reset: got n=%0d x=%0d want 0 0", bus.mbnumber, bus.mb_x);
    end
    bus.save_ready = 1'b1;
    repeat (6) tick();
    nvec++;
    if (fd_count != 0) begin
      nerr++;
      $display("FAIL mid_no_done: got %0d frame_done pulses want 0", fd_count);
    end
    set_defaults();
    drive_frame(ok);
    tick();
    nvec++;
    if (!ok || rec_n[0] !== 0 || ps_count != 8 || fd_count != 1) begin
      nerr++;
      $display("FAIL mid_restart: got ok=%0d n0=%0d ps=%0d fd=%0d want 1 0 8 1",
               ok, rec_n[0], ps_count, fd_count);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_timeout();
    test_collisions();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
